// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// FSM state type, and big-endian lane helpers used on the store (merge)
// and load (extract + extend) paths.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Right-shift that brings the addressed lane down to bit 0. Big-endian:
  // byte k sits at [31-8k -: 8], so the shift is 8*(3-k) = {~k, 3'b000}.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_H) return {~off[1], 4'b0000};
    return {~off, 3'b000};
  endfunction

  // Replace the addressed lane of word with the right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = lane_shift(size, off);
    if (size == SZ_H) mask = 32'h0000_FFFF;
    else              mask = 32'h0000_00FF;
    if (size == SZ_W) return wdata;
    return (word & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  // Pull the addressed lane out of word and sign- or zero-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] v;
    v = word >> lane_shift(size, off);
    case (size)
      SZ_B:    return uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      SZ_H:    return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i[1:0]   : requests, bit n = port n
//   upd_i        : grant taken this cycle; rotate priority
//   gnt_o[1:0]   : one-hot combinational grant (0 when no request)
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
  end

  // After any grant the other port gets priority: port 0 won -> 1, port 1 won -> 0.
  always_comb begin
    prio_d = prio_q;
    if (upd_i && (gnt_o != 2'b00)) prio_d = gnt_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port big-endian data
// memory. Port 0 = CPU LSU, port 1 = debug/loader. Sub-word stores are RMW.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   reqN_i weN_i sizeN_i unsN_i   : per-port request, store flag, size, zero-extend
//   addrN_i wdataN_i              : per-port byte address, right-aligned store data
//   gnt0_o gnt1_o                 : accept pulse
//   done0_o done1_o               : completion pulse to owner
//   rdata_o err_o                 : load result / error, valid with done
//   mem_addr_o mem_we_o mem_wdata_o mem_rdata_i : word-aligned memory port
//
// state | meaning
// IDLE  | waiting; arbitrate, check and latch a request
// READ  | capture word at mem_addr (load, or first half of RMW)
// WRITE | single-cycle memory write
// RESP  | pulse done to owner with rdata/err
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [1:0]  size0_i,
  input  logic [1:0]  size1_i,
  input  logic        uns0_i,
  input  logic        uns1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q, state_d;
  logic        owner_q, we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;

  logic [1:0]  arb_req, arb_gnt;
  logic        accept, sel;
  logic        sel_we, sel_uns, sel_err;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  assign arb_req = {req1_i, req0_i};
  assign accept  = (state_q == IDLE) && (arb_req != 2'b00);
  assign sel     = arb_gnt[1];

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (arb_req),
    .upd_i (accept),
    .gnt_o (arb_gnt)
  );

  assign sel_we    = sel ? we1_i    : we0_i;
  assign sel_size  = sel ? size1_i  : size0_i;
  assign sel_uns   = sel ? uns1_i   : uns0_i;
  assign sel_addr  = sel ? addr1_i  : addr0_i;
  assign sel_wdata = sel ? wdata1_i : wdata0_i;

  assign sel_err = (sel_size == 2'b11)
                || ((sel_size == SZ_H) && sel_addr[0])
                || ((sel_size == SZ_W) && (sel_addr[1:0] != 2'b00))
                || (sel_addr >= 32'(DEPTH));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_err)                           state_d = RESP;
          else if (sel_we && (sel_size == SZ_W)) state_d = WRITE;
          else                                   state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and read capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      if (accept) begin
        owner_q <= sel;
        we_q    <= sel_we;
        uns_q   <= sel_uns;
        err_q   <= sel_err;
        size_q  <= sel_size;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == READ) word_q <= mem_rdata_i;
    end
  end

  assign mem_addr_o = {addr_q[31:2], 2'b00};

  // Outputs
  always_comb begin
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    done0_o     = 1'b0;
    done1_o     = 1'b0;
    rdata_o     = 32'h0;
    err_o       = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 32'h0;
    case (state_q)
      IDLE: begin
        gnt0_o = !rst_i && arb_gnt[0];
        gnt1_o = !rst_i && arb_gnt[1];
      end
      WRITE: begin
        // Reset landing mid-RMW must not leave a partial write behind.
        mem_we_o    = !rst_i;
        mem_wdata_o = lane_merge(word_q, wdata_q, size_q, addr_q[1:0]);
      end
      RESP: begin
        done0_o = !owner_q;
        done1_o = owner_q;
        err_o   = err_q;
        if (!we_q && !err_q) rdata_o = lane_extract(word_q, size_q, addr_q[1:0], uns_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, uns0, uns1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(512)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .size0_i(size0), .size1_i(size1), .uns0_i(uns0), .uns1_i(uns1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .rdata_o(rdata), .err_o(err),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16: return 8'h11;  17: return 8'h22;  18: return 8'h33;  19: return 8'h44;
      20: return 8'hCA;  21: return 8'hFE;  22: return 8'hBA;  23: return 8'hBE;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // Physical memory seen by the DUT
  logic [7:0] mem [0:511];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
    end else if (mem_we && mem_addr < 32'd512) begin
      mem[mem_addr[8:0]]         <= mem_wdata[31:24];
      mem[mem_addr[8:0] + 9'd1]  <= mem_wdata[23:16];
      mem[mem_addr[8:0] + 9'd2]  <= mem_wdata[15:8];
      mem[mem_addr[8:0] + 9'd3]  <= mem_wdata[7:0];
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr < 32'd512)
      mem_rdata = {mem[mem_addr[8:0]], mem[mem_addr[8:0] + 9'd1],
                   mem[mem_addr[8:0] + 9'd2], mem[mem_addr[8:0] + 9'd3]};
  end

  // Reference model state
  logic [7:0]  ref_mem [0:511];
  int          prio;
  logic        p_req [2];
  logic        p_we [2];
  logic        p_uns [2];
  logic [1:0]  p_size [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];

  int          n_chk, n_pass;
  logic [31:0] last_rd, last_wd;
  logic        last_err;
  logic [1:0]  obs_gnt, prev_gnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
        || (a >= 32'd512);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[a[8:0]], ref_mem[a[8:0] + 9'd1], ref_mem[a[8:0] + 9'd2], ref_mem[a[8:0] + 9'd3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    if (sz == 2'd0) begin
      b = ref_mem[a[8:0]];
      return u ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'd1) begin
      h = {ref_mem[a[8:0]], ref_mem[a[8:0] + 9'd1]};
      return u ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return ref_word(a);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) begin
      ref_mem[a[8:0]] = d[7:0];
    end else if (sz == 2'd1) begin
      ref_mem[a[8:0]] = d[15:8];
      ref_mem[a[8:0] + 9'd1] = d[7:0];
    end else begin
      ref_mem[a[8:0]] = d[31:24];
      ref_mem[a[8:0] + 9'd1] = d[23:16];
      ref_mem[a[8:0] + 9'd2] = d[15:8];
      ref_mem[a[8:0] + 9'd3] = d[7:0];
    end
  endtask

  task automatic drive_ports();
    req0 = p_req[0];  we0 = p_we[0];  uns0 = p_uns[0];  size0 = p_size[0];
    addr0 = p_addr[0];  wdata0 = p_wdata[0];
    req1 = p_req[1];  we1 = p_we[1];  uns1 = p_uns[1];  size1 = p_size[1];
    addr1 = p_addr[1];  wdata1 = p_wdata[1];
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
    p_req[p] = 1'b1;  p_we[p] = w;  p_size[p] = sz;  p_uns[p] = u;
    p_addr[p] = a;  p_wdata[p] = d;
  endtask

  task automatic rand_port(input int p);
    int r, s;
    logic [31:0] a;
    s = int'($urandom_range(0, 9));
    r = int'($urandom_range(0, 15));
    if (r < 12)       a = $urandom_range(0, 63);
    else if (r < 14)  a = $urandom_range(500, 520);
    else if (r == 14) a = $urandom();
    else              a = $urandom_range(16, 19);
    set_port(p, 1'($urandom_range(0, 1)), (s == 9) ? 2'd3 : 2'(s / 3),
             1'($urandom_range(0, 1)), a, $urandom());
  endtask

  // Runs one arbitration + full operation starting just after a rising edge
  // with the DUT idle. hold keeps the winner's req asserted throughout.
  task automatic issue_round(input bit hold);
    int w, lat, wcyc;
    bit e;
    logic [31:0] a, exp_rd, exp_wd;
    logic [1:0] sz;
    drive_ports();
    if (!p_req[0] && !p_req[1]) return;
    w = (p_req[0] && p_req[1]) ? prio : (p_req[0] ? 0 : 1);
    prio = 1 - w;
    a  = p_addr[w];
    sz = p_size[w];
    e  = ref_err(sz, a);
    exp_rd = 32'h0;
    exp_wd = 32'h0;
    if (e) begin
      lat = 1;  wcyc = 0;
    end else if (p_we[w]) begin
      ref_store(a, sz, p_wdata[w]);
      exp_wd = ref_word(a & 32'hFFFF_FFFC);
      lat  = (sz == 2'd2) ? 2 : 3;
      wcyc = lat - 1;
    end else begin
      exp_rd = ref_load(a, sz, p_uns[w]);
      lat = 2;  wcyc = 0;
    end
    @(negedge clk);
    obs_gnt = {gnt1, gnt0};
    check_val("gnt", 32'(obs_gnt), (w == 0) ? 32'd1 : 32'd2);
    check_val("we_accept", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    if (!hold) p_req[w] = 1'b0;
    drive_ports();
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check_val("gnt_busy", 32'({gnt1, gnt0}), 32'd0);
      check_val("done0", 32'(done0), 32'(w == 0 && k == lat));
      check_val("done1", 32'(done1), 32'(w == 1 && k == lat));
      check_val("mem_we", 32'(mem_we), 32'(k == wcyc));
      check_val("mem_wdata", mem_wdata, (k == wcyc) ? exp_wd : 32'h0);
      check_val("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      if (k == lat) begin
        check_val("rdata", rdata, exp_rd);
        check_val("err", 32'(err), 32'(e));
        last_rd  = rdata;
        last_err = err;
      end else begin
        check_val("rdata_idle", rdata, 32'h0);
      end
      if (k == wcyc) last_wd = mem_wdata;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nbad;
    n_chk = 0;  n_pass = 0;  prio = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0;  p_we[p] = 0;  p_uns[p] = 0;  p_size[p] = 0;  p_addr[p] = 0;  p_wdata[p] = 0;
    end
    drive_ports();
    req0 = 1'b1;
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check_val("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check_val("rst_done", 32'({done1, done0}), 32'd0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_we", 32'(mem_we), 32'd0);
    check_val("rst_addr", mem_addr, 32'h0);
    check_val("rst_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_ports();

    // Directed loads and RMW store over 0x11223344 at 0x10
    set_port(0, 0, 2'd0, 0, 32'h11, 0);  issue_round(0);
    check_val("ld_b11", last_rd, 32'h0000_0022);
    set_port(0, 0, 2'd1, 0, 32'h12, 0);  issue_round(0);
    check_val("ld_h12", last_rd, 32'h0000_3344);
    set_port(1, 1, 2'd0, 0, 32'h12, 32'h0000_00AB);  issue_round(0);
    check_val("st_b12_wd", last_wd, 32'h1122_AB44);
    set_port(0, 0, 2'd2, 0, 32'h10, 0);  issue_round(0);
    check_val("ld_w10", last_rd, 32'h1122_AB44);
    set_port(0, 1, 2'd0, 0, 32'h13, 32'hFFFF_FF80);  issue_round(0);
    set_port(0, 0, 2'd0, 0, 32'h13, 0);  issue_round(0);
    check_val("ld_b13_s", last_rd, 32'hFFFF_FF80);
    set_port(0, 0, 2'd0, 1, 32'h13, 0);  issue_round(0);
    check_val("ld_b13_u", last_rd, 32'h0000_0080);

    // Error requests
    set_port(0, 0, 2'd2, 0, 32'h102, 0);  issue_round(0);
    check_val("err_w102", 32'(last_err), 32'd1);
    set_port(1, 1, 2'd1, 0, 32'h7, 32'h1234);  issue_round(0);
    check_val("err_h7", 32'(last_err), 32'd1);
    set_port(0, 0, 2'd2, 0, 32'h200, 0);  issue_round(0);
    check_val("err_w200", 32'(last_err), 32'd1);
    check_val("err_rdata", last_rd, 32'h0);

    // Both ports requesting continuously
    set_port(0, 0, 2'd2, 0, 32'h20, 0);
    set_port(1, 0, 2'd1, 1, 32'h22, 0);
    prev_gnt = 2'b00;
    for (int i = 0; i < 6; i++) begin
      issue_round(1);
      if (i > 0) check_val("alternate", 32'(obs_gnt == prev_gnt), 32'd0);
      prev_gnt = obs_gnt;
    end
    p_req[0] = 0;  p_req[1] = 0;  drive_ports();

    // Reset during the READ cycle of a sub-word store
    set_port(1, 1, 2'd0, 0, 32'h15, 32'h5A);
    drive_ports();
    @(negedge clk);
    check_val("mid_gnt1", 32'(gnt1), 32'd1);
    @(posedge clk); #1;
    p_req[1] = 0;  drive_ports();
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    prio = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("mid_done", 32'({done1, done0}), 32'd0);
      check_val("mid_we2", 32'(mem_we), 32'd0);
      check_val("mid_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
    end
    check_val("mid_mem", {mem[20], mem[21], mem[22], mem[23]}, 32'hCAFE_BABE);
    set_port(0, 0, 2'd2, 0, 32'h14, 0);
    set_port(1, 0, 2'd2, 0, 32'h18, 0);
    issue_round(0);
    check_val("post_rst_gnt", 32'(obs_gnt), 32'd1);
    check_val("post_rst_ld", last_rd, 32'hCAFE_BABE);

    // Randomized traffic
    for (int r = 0; r < 200; r++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 1) == 1) rand_port(p);
      if (!p_req[0] && !p_req[1]) rand_port(int'($urandom_range(0, 1)));
      issue_round(0);
    end
    p_req[0] = 0;  p_req[1] = 0;  drive_ports();
    repeat (2) @(posedge clk);

    nbad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check_val("mem_final", 32'(nbad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
